// File: rtl/wb_pattern_master_if.sv
// Wishbone classic bus bundle between the pattern master and an SDRAM-side slave.
// Signal suffixes are from the master's point of view.
interface wb_pattern_master_if #(
  parameter int DW = 32,
  parameter int AW = 26
);
  logic              wb_cyc_o;
  logic              wb_stb_o;
  logic              wb_we_o;
  logic [AW-1:0]     wb_addr_o;
  logic [DW-1:0]     wb_dat_o;
  logic [DW/8-1:0]   wb_sel_o;
  logic [2:0]        wb_cti_o;
  logic              wb_ack_i;
  logic [DW-1:0]     wb_dat_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
    input  wb_ack_i, wb_dat_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
    output wb_ack_i, wb_dat_i
  );
endinterface

// File: rtl/wb_pattern_master.sv
// Memory test master: writes an incrementing pattern as a Wishbone burst, reads it
// back, counts mismatches and reports pass/fail, with an ack timeout as the only abort.
module wb_pattern_master #(
  parameter int DW  = 32,
  parameter int AW  = 26,
  parameter int BL  = 5,
  parameter int TMO = 1023
) (
  input  logic                sys_clk,
  input  logic                RESETN,
  input  logic                sdr_init_done,
  input  logic                start,
  input  logic [AW-1:0]       base_addr,
  input  logic [BL-1:0]       burst_len,
  input  logic [DW-1:0]       seed,
  wb_pattern_master_if.master wb,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                timeout,
  output logic [BL:0]         err_cnt,
  output logic [AW-1:0]       first_err_addr
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_INIT, S_WRITE, S_TURN, S_READ, S_DONE
  } state_t;

  localparam int            TW       = 16;
  localparam int            BYTES    = DW / 8;
  localparam logic [BL:0]   ONE_BEAT = 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);
  localparam logic [2:0]    CTI_INCR = 3'b010;
  localparam logic [2:0]    CTI_EOB  = 3'b111;

  state_t        state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [DW-1:0] seed_q, seed_d;
  logic [BL:0]   last_q, last_d;
  logic [BL:0]   beat_q, beat_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          pass_q, pass_d;
  logic          timeout_q, timeout_d;
  logic [BL:0]   err_q, err_d;
  logic [AW-1:0] ferr_q, ferr_d;

  logic          active;
  logic          is_last;
  logic [AW-1:0] beat_addr;
  logic [DW-1:0] beat_data;

  // Beat address/data are derived from the sampled base/seed so a held beat stays stable.
  assign active    = (state_q == S_WRITE) || (state_q == S_READ);
  assign is_last   = (beat_q == last_q);
  assign beat_addr = base_q + AW'(beat_q) * AW'(BYTES);
  assign beat_data = seed_q + DW'(beat_q);

  // NOTE: every variable gets its default before the case so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    seed_d    = seed_q;
    last_d    = last_q;
    beat_d    = beat_q;
    tmo_d     = tmo_q;
    pass_d    = pass_q;
    timeout_d = timeout_q;
    err_d     = err_q;
    ferr_d    = ferr_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          base_d    = base_addr;
          seed_d    = seed;
          last_d    = (burst_len == '0) ? {1'b0, {BL{1'b1}}} : ({1'b0, burst_len} - ONE_BEAT);
          beat_d    = '0;
          tmo_d     = '0;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          err_d     = '0;
          ferr_d    = '0;
          state_d   = sdr_init_done ? S_WRITE : S_WAIT_INIT;
        end
      end

      S_WAIT_INIT: begin
        if (sdr_init_done) state_d = S_WRITE;
      end

      S_WRITE, S_READ: begin
        if (wb.wb_ack_i) begin
          tmo_d = '0;
          if (state_q == S_READ && wb.wb_dat_i != beat_data) begin
            if (err_q != '1) err_d = err_q + ONE_BEAT;
            if (err_q == '0) ferr_d = beat_addr;
          end
          if (is_last) begin
            beat_d = '0;
            if (state_q == S_WRITE) begin
              state_d = S_TURN;
            end else begin
              state_d = S_DONE;
              pass_d  = (err_d == '0) && !timeout_q;
            end
          end else begin
            beat_d = beat_q + ONE_BEAT;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end

      S_TURN: begin
        tmo_d   = '0;
        state_d = S_READ;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  // NOTE: every flop, data registers included, is cleared by reset so all outputs read 0 immediately.
  always_ff @(posedge sys_clk or negedge RESETN) begin
    if (!RESETN) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      seed_q    <= '0;
      last_q    <= '0;
      beat_q    <= '0;
      tmo_q     <= '0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= '0;
      ferr_q    <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      seed_q    <= seed_d;
      last_q    <= last_d;
      beat_q    <= beat_d;
      tmo_q     <= tmo_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
      ferr_q    <= ferr_d;
    end
  end

  // Bus outputs are gated by the active phase so idle and reset drive all-zero.
  always_comb begin
    wb.wb_cyc_o  = active;
    wb.wb_stb_o  = active;
    wb.wb_we_o   = (state_q == S_WRITE);
    wb.wb_addr_o = active ? beat_addr : '0;
    wb.wb_dat_o  = (state_q == S_WRITE) ? beat_data : '0;
    wb.wb_sel_o  = active ? '1 : '0;
    wb.wb_cti_o  = active ? (is_last ? CTI_EOB : CTI_INCR) : 3'b000;
  end

  assign busy           = (state_q == S_WAIT_INIT) || (state_q == S_WRITE) ||
                          (state_q == S_TURN)      || (state_q == S_READ);
  assign done           = (state_q == S_DONE);
  assign pass           = pass_q;
  assign timeout        = timeout_q;
  assign err_cnt        = err_q;
  assign first_err_addr = ferr_q;

endmodule

// File: doc/wb_pattern_master.md
WB_PATTERN_MASTER -- requirements
Module: wb_pattern_master

Interface
REQ-001 SHALL have parameter DW, default 32, Wishbone data width (multiple of 8).
REQ-002 SHALL have parameter AW, default 26, Wishbone byte-address width.
REQ-003 SHALL have parameter BL, default 5, burst-length field width; max burst 2^BL words.
REQ-004 SHALL have parameter TMO, default 1023, ack timeout in cycles (1..65535).
REQ-005 sys_clk  in  1  single clock; all logic rising-edge.
REQ-006 RESETN  in  1  asynchronous, active-low reset.
REQ-007 sdr_init_done  in  1  SDRAM controller initialisation complete.
REQ-008 start  in  1  one-cycle request to run a write/read-back pass.
REQ-009 base_addr  in  AW  byte start address, sampled on accepted start.
REQ-010 burst_len  in  BL  words per pass, sampled on accepted start; 0 means 2^BL.
REQ-011 seed  in  DW  first data word, sampled on accepted start.
REQ-012 wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone cycle, strobe, write enable.
REQ-013 wb_addr_o  out  AW; wb_dat_o  out  DW; wb_sel_o  out  DW/8; wb_cti_o  out  3.
REQ-014 wb_ack_i  in  1; wb_dat_i  in  DW  slave acknowledge and read data.
REQ-015 busy, done, pass, timeout  out  1 each  status flags.
REQ-016 err_cnt  out  BL+1  mismatching read words; first_err_addr  out  AW  byte address of first mismatch.

Function
REQ-017 States SHALL be IDLE, WAIT_INIT, WRITE, TURN, READ, DONE.
REQ-018 start SHALL be accepted only in IDLE or DONE; ignored otherwise; acceptance clears done, pass, timeout, err_cnt, first_err_addr.
REQ-019 On accept: go to WRITE if sdr_init_done=1, else WAIT_INIT; WAIT_INIT leaves for WRITE on first cycle sdr_init_done=1.
REQ-020 busy SHALL be 1 in WAIT_INIT, WRITE, TURN, READ; 0 in IDLE and DONE.
REQ-021 WRITE/READ: cyc=stb=1, sel all-ones; beat i address = base_addr + i*(DW/8) modulo 2^AW; write data = seed + i modulo 2^DW.
REQ-022 Beat i SHALL be held stable until a cycle with wb_ack_i=1; next beat presented the following cycle, no idle gap (classic pipelined-free burst).
REQ-023 wb_cti_o SHALL be 3'b010 on all beats except last, 3'b111 on last beat of each phase.
REQ-024 wb_ack_i while cyc=0 SHALL be ignored.
REQ-025 After last write ack: TURN for exactly one cycle with cyc=stb=we=0, then READ from beat 0; we=0 in READ.
REQ-026 READ: on each ack compare wb_dat_i with seed+i; mismatch increments err_cnt (saturates at all-ones) and, if first, latches beat address into first_err_addr.
REQ-027 After last read ack: DONE; done=1, pass=1 iff err_cnt=0 and timeout=0; cyc/stb deasserted same cycle.
REQ-028 Timeout counter SHALL reset on every beat presentation/ack; if TMO consecutive cycles with stb=1 and no ack, go to DONE with timeout=1, pass=0, cyc/stb dropped next cycle.
REQ-029 sdr_init_done falling mid-burst SHALL NOT abort; only the timeout aborts.
REQ-030 done, pass, timeout, err_cnt, first_err_addr SHALL hold in DONE until next accepted start.
REQ-031 Beat counter width BL+1; burst_len=0 runs 2^BL beats per phase.

Reset
REQ-032 RESETN low SHALL asynchronously force IDLE and all outputs to 0 (wb_cti_o=3'b000, wb_sel_o=0), including mid-burst; first start is accepted on first clock after RESETN high.

Verification
REQ-033 Ideal slave, zero-wait ack, base_addr=0x100, burst_len=4, seed=0xA5A5_0000 -> writes 0xA5A50000..0xA5A50003 at 0x100,0x104,0x108,0x10C, cti 010,010,010,111; one-cycle TURN; done=1 pass=1 err_cnt=0.
REQ-034 Slave corrupts read beat 2 (bit0 flipped), burst_len=4, base_addr=0x200 -> err_cnt=1, first_err_addr=0x208, pass=0.
REQ-035 sdr_init_done=0 for 50 cycles after start -> cyc stays 0 until init rises, busy=1 throughout.
REQ-036 Slave never acks, TMO=16 -> after 16 stb cycles timeout=1, done=1, pass=0, cyc=0.
REQ-037 burst_len=0, seed=0xFFFF_FFFE, base_addr=2^AW-8 -> 32 beats, data wraps to 0x00000000 at beat 2, address wraps to 0.
REQ-038 RESETN pulsed low during READ beat 1 -> all outputs 0 immediately; new start afterwards completes with pass=1.
